pipe_trace_buffer: RTL and testbench

Synthesisable, parametrised pipeline trace recorder for the processor core. Each cycle it captures every stage's PC and nop bit into a circular buffer, stops a programmable number of samples after a trigger (external event or PC match), then streams the frozen history oldest-first over a valid/ready port. It replaces per-cycle pipeline printing with an on-chip, trigger-qualified trace that works in silicon and in simulation alike.

---
 rtl/pipe_trace_buffer.sv | 113 +++++++++++
 tb/tb_pipe_trace_buffer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_trace_buffer.sv
// rtl/pipe_trace_buffer.sv - trigger-qualified circular trace of per-stage PC and nop bits
module pipe_trace_buffer #(
  parameter int STAGES = 5,
  parameter int PC_W   = 12,
  parameter int DEPTH  = 16,
  parameter int CW     = $clog2(DEPTH) + 1,
  parameter int SW     = STAGES * (PC_W + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 arm,
  input  logic                 stall,
  input  logic [STAGES*PC_W-1:0] stage_pc,
  input  logic [STAGES-1:0]    stage_nop,
  input  logic                 trig_ext,
  input  logic                 trig_pc_en,
  input  logic [PC_W-1:0]      trig_pc,
  input  logic [CW-1:0]        post_cnt,
  input  logic                 rd_ready,
  output logic                 rd_valid,
  output logic [SW-1:0]        rd_data,
  output logic                 rd_last,
  output logic                 busy,
  output logic                 done,
  output logic                 wrapped,
  output logic [CW-1:0]        count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] MAX_POST = CW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL     = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, ARMED, POST, DONE} state_t;

  state_t          state, state_nx;
  logic [AW-1:0]   wp;
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   remaining;
  logic            wrapped_q;
  logic [SW-1:0]   mem [DEPTH];
  logic [SW-1:0]   sample_word;
  logic [CW-1:0]   pc_eff;
  logic [AW-1:0]   rd_ptr;
  logic            sample, trig_hit, xfer;

  always_comb begin
    sample_word = '0;
    for (int i = 0; i < STAGES; i++)
      sample_word[i*(PC_W+1) +: PC_W+1] = {stage_nop[i], stage_pc[i*PC_W +: PC_W]};
  end

  // arm outranks sampling, triggering and reading on the same edge
  assign sample   = (state == ARMED || state == POST) && !stall && !arm;
  assign trig_hit = trig_ext | (trig_pc_en & (stage_pc[PC_W-1:0] == trig_pc) & ~stage_nop[0]);
  assign pc_eff   = (post_cnt > MAX_POST) ? MAX_POST : post_cnt;
  assign xfer     = rd_valid & rd_ready;

  always_comb begin
    state_nx = state;
    if (arm) begin
      state_nx = ARMED;
    end else begin
      case (state)
        ARMED:   if (sample && trig_hit) state_nx = (pc_eff == '0) ? DONE : POST;
        POST:    if (sample && remaining == CW'(1)) state_nx = DONE;
        DONE:    if (count_q == '0 || (xfer && count_q == CW'(1))) state_nx = IDLE;
        default: state_nx = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      wp        <= '0;
      count_q   <= '0;
      remaining <= '0;
      wrapped_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (arm) begin
        wp        <= '0;
        count_q   <= '0;
        remaining <= '0;
        wrapped_q <= 1'b0;
      end else begin
        if (sample) begin
          wp <= wp + 1'b1;
          if (count_q == FULL) wrapped_q <= 1'b1;
          else                 count_q   <= count_q + 1'b1;
        end
        if (state == ARMED && sample && trig_hit) remaining <= pc_eff;
        else if (state == POST && sample)         remaining <= remaining - 1'b1;
        if (xfer) count_q <= count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (sample) mem[wp] <= sample_word;
  end

  // oldest entry sits count slots behind the write pointer
  assign rd_ptr   = wp - count_q[AW-1:0];
  assign rd_valid = (state == DONE) && (count_q != '0);
  assign rd_last  = rd_valid && (count_q == CW'(1));
  assign rd_data  = rd_valid ? mem[rd_ptr] : '0;
  assign busy     = (state == ARMED) || (state == POST);
  assign done     = (state == DONE);
  assign wrapped  = wrapped_q;
  assign count    = count_q;

endmodule

// File: tb/tb_pipe_trace_buffer.sv
// tb/tb_pipe_trace_buffer.sv - directed self-checking bench for pipe_trace_buffer
module tb_pipe_trace_buffer;

  localparam int STAGES = 5;
  localparam int PC_W   = 12;
  localparam int DEPTH  = 8;
  localparam int CW     = 4;
  localparam int SW     = STAGES * (PC_W + 1);

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   arm = 1'b0;
  logic                   stall = 1'b0;
  logic [STAGES*PC_W-1:0] stage_pc = '0;
  logic [STAGES-1:0]      stage_nop = '0;
  logic                   trig_ext = 1'b0;
  logic                   trig_pc_en = 1'b0;
  logic [PC_W-1:0]        trig_pc = '0;
  logic [CW-1:0]          post_cnt = '0;
  logic                   rd_ready = 1'b0;
  logic                   rd_valid;
  logic [SW-1:0]          rd_data;
  logic                   rd_last;
  logic                   busy;
  logic                   done;
  logic                   wrapped;
  logic [CW-1:0]          count;

  int checks = 0;
  int errors = 0;

  pipe_trace_buffer #(.STAGES(STAGES), .PC_W(PC_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .arm(arm), .stall(stall),
    .stage_pc(stage_pc), .stage_nop(stage_nop), .trig_ext(trig_ext),
    .trig_pc_en(trig_pc_en), .trig_pc(trig_pc), .post_cnt(post_cnt),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_last(rd_last), .busy(busy), .done(done), .wrapped(wrapped),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // stage i carries base + 16*i; stage 4 always nop, stage 0 nop under control
  task automatic drive(input logic [PC_W-1:0] base, input logic nop0);
    for (int i = 0; i < STAGES; i++)
      stage_pc[i*PC_W +: PC_W] = base + PC_W'(i * 16);
    stage_nop = {1'b1, 3'b000, nop0};
  endtask

  function automatic logic [SW-1:0] exp_entry(input logic [PC_W-1:0] base, input logic nop0);
    logic [SW-1:0] e;
    e = '0;
    for (int i = 0; i < STAGES; i++)
      e[i*(PC_W+1) +: PC_W+1] = {(i == 0) ? nop0 : (i == STAGES - 1), base + PC_W'(i * 16)};
    return e;
  endfunction

  task automatic samp(input logic [PC_W-1:0] base, input logic te);
    drive(base, 1'b0);
    trig_ext = te;
    tick();
    trig_ext = 1'b0;
  endtask

  task automatic rd_expect(input string tag, input logic [PC_W-1:0] base, input logic nop0, input logic last);
    chk({tag, "_valid"}, rd_valid, 1'b1);
    chk({tag, "_data"}, rd_data, exp_entry(base, nop0));
    chk({tag, "_last"}, rd_last, last);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    tick();
    tick();
    chk("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_rd_last", rd_last, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_wrapped", wrapped, 1'b0);
    chk("rst_count", count, 4'd0);
    chk("rst_rd_data", rd_data, '0);
    reset = 1'b1;
    tick();

    // basic capture
    post_cnt = 4'd2;
    do_arm();
    chk("b_busy_arm", busy, 1'b1);
    chk("b_count_arm", count, 4'd0);
    samp(12'd1, 1'b0);
    samp(12'd2, 1'b0);
    samp(12'd3, 1'b0);
    samp(12'd4, 1'b1);
    chk("b_count_trig", count, 4'd4);
    chk("b_done_trig", done, 1'b0);
    samp(12'd5, 1'b0);
    chk("b_done_p1", done, 1'b0);
    samp(12'd6, 1'b0);
    chk("b_done", done, 1'b1);
    chk("b_busy_done", busy, 1'b0);
    chk("b_count", count, 4'd6);
    for (int k = 1; k <= 6; k++)
      rd_expect("b_rd", PC_W'(k), 1'b0, k == 6);
    chk("b_idle_done", done, 1'b0);
    chk("b_idle_busy", busy, 1'b0);
    chk("b_idle_count", count, 4'd0);
    chk("b_idle_valid", rd_valid, 1'b0);

    // wrap-around
    do_arm();
    for (int b = 1; b <= 20; b++) begin
      samp(PC_W'(b), 1'b0);
      if (b == 8) begin
        chk("w_count8", count, 4'd8);
        chk("w_wrapped8", wrapped, 1'b0);
      end
      if (b == 9) chk("w_wrapped9", wrapped, 1'b1);
    end
    samp(12'd21, 1'b1);
    samp(12'd22, 1'b0);
    samp(12'd23, 1'b0);
    chk("w_done", done, 1'b1);
    chk("w_count", count, 4'd8);
    chk("w_wrapped", wrapped, 1'b1);
    for (int k = 16; k <= 23; k++)
      rd_expect("w_rd", PC_W'(k), 1'b0, k == 23);
    chk("w_idle_count", count, 4'd0);

    // stall and nop qualification
    trig_pc_en = 1'b1;
    trig_pc = 12'h040;
    post_cnt = 4'd0;
    do_arm();
    drive(12'h040, 1'b0);
    stall = 1'b1;
    trig_ext = 1'b1;
    tick();
    stall = 1'b0;
    trig_ext = 1'b0;
    chk("s_stall_busy", busy, 1'b1);
    chk("s_stall_done", done, 1'b0);
    chk("s_stall_count", count, 4'd0);
    drive(12'h040, 1'b1);
    tick();
    chk("s_nop_busy", busy, 1'b1);
    chk("s_nop_count", count, 4'd1);
    drive(12'h040, 1'b0);
    tick();
    chk("s_match_done", done, 1'b1);
    chk("s_match_count", count, 4'd2);
    trig_pc_en = 1'b0;
    rd_expect("s_rd0", 12'h040, 1'b1, 1'b0);
    rd_expect("s_rd1", 12'h040, 1'b0, 1'b1);
    samp(12'h050, 1'b1);
    chk("s_idle_trig_busy", busy, 1'b0);
    chk("s_idle_trig_done", done, 1'b0);
    chk("s_idle_trig_count", count, 4'd0);

    // post clamp, stall in POST, backpressure
    post_cnt = 4'd15;
    do_arm();
    samp(12'h100, 1'b1);
    samp(12'h101, 1'b0);
    samp(12'h102, 1'b0);
    samp(12'h103, 1'b0);
    drive(12'h1ff, 1'b0);
    stall = 1'b1;
    tick();
    stall = 1'b0;
    chk("p_stall_busy", busy, 1'b1);
    chk("p_stall_count", count, 4'd4);
    samp(12'h104, 1'b0);
    samp(12'h105, 1'b0);
    samp(12'h106, 1'b0);
    chk("p_done6", done, 1'b0);
    chk("p_count6", count, 4'd7);
    samp(12'h107, 1'b0);
    chk("p_done", done, 1'b1);
    chk("p_count", count, 4'd8);
    chk("p_wrapped", wrapped, 1'b0);
    for (int k = 0; k < 4; k++)
      rd_expect("p_rd", 12'h100 + PC_W'(k), 1'b0, 1'b0);
    for (int h = 0; h < 3; h++) begin
      tick();
      chk("p_hold_data", rd_data, exp_entry(12'h104, 1'b0));
      chk("p_hold_last", rd_last, 1'b0);
      chk("p_hold_count", count, 4'd4);
    end
    for (int k = 4; k < 8; k++)
      rd_expect("p_rd", 12'h100 + PC_W'(k), 1'b0, k == 7);
    chk("p_idle_count", count, 4'd0);

    // async reset mid-POST
    post_cnt = 4'd5;
    do_arm();
    samp(12'd1, 1'b1);
    samp(12'd2, 1'b0);
    chk("r_pre_busy", busy, 1'b1);
    chk("r_pre_count", count, 4'd2);
    #3;
    reset = 1'b0;
    #1;
    chk("r_busy", busy, 1'b0);
    chk("r_count", count, 4'd0);
    chk("r_done", done, 1'b0);
    chk("r_valid", rd_valid, 1'b0);
    chk("r_last", rd_last, 1'b0);
    chk("r_wrapped", wrapped, 1'b0);
    chk("r_data", rd_data, '0);
    tick();
    reset = 1'b1;
    tick();

    // re-arm while DONE
    post_cnt = 4'd4;
    do_arm();
    samp(12'h200, 1'b1);
    for (int k = 1; k <= 4; k++) samp(12'h200 + PC_W'(k), 1'b0);
    chk("a_done", done, 1'b1);
    chk("a_count5", count, 4'd5);
    do_arm();
    chk("a_rearm_count", count, 4'd0);
    chk("a_rearm_busy", busy, 1'b1);
    chk("a_rearm_done", done, 1'b0);
    post_cnt = 4'd1;
    samp(12'h300, 1'b1);
    samp(12'h301, 1'b0);
    chk("a_done2", done, 1'b1);
    chk("a_count2", count, 4'd2);
    rd_expect("a_rd0", 12'h300, 1'b0, 1'b0);
    rd_expect("a_rd1", 12'h301, 1'b0, 1'b1);
    chk("a_idle_busy", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
